// File: rtl/lfsr_arbiter_pkg.sv
// Shared definitions for the LFSR arbiter slice.
//   LFSR_W       : width of the pseudo-random generator
//   state_t      : arbiter FSM encoding (ST_LOAD, ST_SERVE)
//   DEFAULT_SEED : non-zero value loaded into the generator on (re)seed
//   lfsr_next()  : one generator step, taps give a maximal period of 7
package lfsr_arbiter_pkg;

  localparam int LFSR_W = 3;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 3'b001;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[1], q[2] ^ q[0], q[2]};
  endfunction

endpackage

// File: rtl/lfsr_arbiter_lfsr_step.sv
// 3-bit LFSR register with seed load and step enable.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset, clears the register to 000
//   load    : load seed (has priority over step)
//   step    : advance the generator by one step
//   seed    : value loaded when load is high
//   q       : current register contents
module lfsr_step
  import lfsr_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= seed;
    end else if (step) begin
      q_reg <= lfsr_next(q_reg);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter sharing one 3-bit LFSR between N_REQ requesters.
// Each grant hands the current LFSR word to one requester and steps the
// generator. The LFSR is seeded after reset, on a reseed pulse, and when it
// is found in the all-zero lock-up state.
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   req       : per-requester request level, held until granted
//   reseed    : single-cycle pulse requesting a reload of SEED
//   gnt       : registered one-hot (or zero) single-cycle grant
//   rnd_valid : registered, high exactly when gnt is non-zero
//   rnd_data  : registered LFSR word for the granted requester, holds otherwise
//   rnd_id    : registered index of the granted requester
//   busy      : high while the seed is being loaded (no grants)
module lfsr_arbiter
  import lfsr_arbiter_pkg::*;
#(
  parameter int                N_REQ = 4,
  parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_REQ-1:0]  req,
  input  logic              reseed,
  output logic [N_REQ-1:0]  gnt,
  output logic              rnd_valid,
  output logic [LFSR_W-1:0] rnd_data,
  output logic [1:0]        rnd_id,
  output logic              busy
);

  state_t            state_reg, state_next;
  logic [1:0]        ptr_reg;
  logic [N_REQ-1:0]  gnt_reg;
  logic              valid_reg;
  logic [LFSR_W-1:0] data_reg;
  logic [1:0]        id_reg;

  logic [LFSR_W-1:0] q;
  logic              lfsr_load;
  logic              lfsr_step_en;
  logic              do_grant;

  // A requester granted last cycle still shows req high; mask it for one
  // cycle so the same request is not granted twice.
  logic [N_REQ-1:0]  eligible;
  assign eligible = req & ~gnt_reg;

  // Candidate gi is the requester gi positions above ptr (2-bit wrap).
  logic [1:0]        cand_idx [N_REQ];
  logic [N_REQ-1:0]  cand_hit;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = ptr_reg + 2'(gi);
    assign cand_hit[gi] = eligible[cand_idx[gi]];
  end

  // Lowest-offset hit wins; scanning downward leaves the nearest one.
  logic       sel_found;
  logic [1:0] sel_idx;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx[i];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    lfsr_load    = 1'b0;
    lfsr_step_en = 1'b0;
    do_grant     = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        // reseed is ignored here: the seed is already going in.
        lfsr_load  = 1'b1;
        state_next = ST_SERVE;
      end
      ST_SERVE: begin
        // A zero LFSR would never leave 000, so reload instead of granting.
        if (reseed || (q == '0)) begin
          state_next = ST_LOAD;
        end else if (sel_found) begin
          do_grant     = 1'b1;
          lfsr_step_en = 1'b1;
        end
      end
      default: state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg   <= '0;
      gnt_reg   <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      id_reg    <= '0;
    end else begin
      valid_reg <= do_grant;
      if (do_grant) begin
        gnt_reg  <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
        data_reg <= q;
        id_reg   <= sel_idx;
        ptr_reg  <= sel_idx + 2'd1;
      end else begin
        gnt_reg  <= '0;
      end
    end
  end

  lfsr_step u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .step    (lfsr_step_en),
    .seed    (SEED),
    .q       (q)
  );

  assign gnt       = gnt_reg;
  assign rnd_valid = valid_reg;
  assign rnd_data  = data_reg;
  assign rnd_id    = id_reg;
  assign busy      = (state_reg == ST_LOAD);

endmodule

// File: tb/tb_lfsr_arbiter.sv
module tb_lfsr_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic       reseed;
  logic [3:0] gnt;
  logic       rnd_valid;
  logic [2:0] rnd_data;
  logic [1:0] rnd_id;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  lfsr_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .reseed    (reseed),
    .gnt       (gnt),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .rnd_id    (rnd_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: the generator is the published period-7 sequence,
  // tracked as a position in that table (or a lock-up flag for Q == 000).
  int         seq [7] = '{1, 2, 4, 3, 6, 7, 5};
  bit         m_loading;
  bit         m_q_zero;
  int         m_q_idx;
  int         m_ptr;
  logic [3:0] m_gnt;
  logic       m_valid;
  logic [2:0] m_data;
  logic [1:0] m_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b1;
    m_q_zero  = 1'b1;
    m_q_idx   = 0;
    m_ptr     = 0;
    m_gnt     = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_id      = '0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic rs);
    logic [3:0] elig;
    bit         found;
    int         sel;
    if (m_loading) begin
      m_loading = 1'b0;
      m_q_zero  = 1'b0;
      m_q_idx   = 0;
      m_gnt     = '0;
      m_valid   = 1'b0;
    end else if (rs || m_q_zero) begin
      m_loading = 1'b1;
      m_gnt     = '0;
      m_valid   = 1'b0;
    end else begin
      elig  = r & ~m_gnt;
      found = 1'b0;
      sel   = 0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (!found && elig[c]) begin
          found = 1'b1;
          sel   = c;
        end
      end
      if (found) begin
        m_gnt   = 4'(1) << sel;
        m_valid = 1'b1;
        m_data  = 3'(seq[m_q_idx]);
        m_id    = 2'(sel);
        m_q_idx = (m_q_idx + 1) % 7;
        m_ptr   = (sel + 1) % 4;
      end else begin
        m_gnt   = '0;
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("gnt", 32'(gnt), 32'(m_gnt));
    check("rnd_valid", 32'(rnd_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_loading));
    check("rnd_data", 32'(rnd_data), 32'(m_data));
    if (m_valid) check("rnd_id", 32'(rnd_id), 32'(m_id));
  endtask

  // Called away from the rising edge; drives inputs, clocks once, checks.
  task automatic tick(input logic [3:0] r, input logic rs);
    req    = r;
    reseed = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
    compare_all();
    if (rnd_valid) $display("grant id=%0d data=%0d gnt=%b", rnd_id, rnd_data, gnt);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases on negedge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async_clear_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int         n_grants;
  logic [2:0] got [8];
  int         exp_single [8] = '{1, 2, 4, 3, 6, 7, 5, 1};
  int         exp_rr_id   [5] = '{0, 1, 2, 3, 0};
  int         exp_rr_data [5] = '{1, 2, 4, 3, 6};

  initial begin
    req     = '0;
    reseed  = 1'b0;
    reset_n = 1'b1;
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    compare_all();
    check("q_reset", 32'(dut.u_lfsr.q_reg), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset release: LOAD then SERVE with Q seeded.
    tick(4'b0000, 1'b0);
    check("q_seeded", 32'(dut.u_lfsr.q_reg), 32'd1);
    tick(4'b0000, 1'b0);

    // Single requester held: grant every other cycle, period-7 wrap.
    n_grants = 0;
    for (int i = 0; i < 16; i++) begin
      tick(4'b0100, 1'b0);
      if (rnd_valid && n_grants < 8) begin
        got[n_grants] = rnd_data;
        n_grants++;
      end
    end
    check("single_grant_count", 32'(n_grants), 32'd8);
    for (int i = 0; i < 8; i++) check("single_seq", 32'(got[i]), 32'(exp_single[i]));
    tick(4'b0000, 1'b0);

    // All requesting from a fresh seed: rotation 0,1,2,3,0.
    do_reset();
    tick(4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(4'b1111, 1'b0);
      check("rr_id", 32'(rnd_id), 32'(exp_rr_id[i]));
      check("rr_data", 32'(rnd_data), 32'(exp_rr_data[i]));
    end

    // Reseed after three grants with requests pending.
    do_reset();
    tick(4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) tick(4'b0011, 1'b0);
    tick(4'b0011, 1'b1);
    check("reseed_busy", 32'(busy), 32'd1);
    check("reseed_nogrant", 32'(gnt), 32'd0);
    tick(4'b0011, 1'b0);
    check("reseed_load_nogrant", 32'(gnt), 32'd0);
    tick(4'b0011, 1'b0);
    check("reseed_gnt", 32'(gnt), 32'b0010);
    check("reseed_data", 32'(rnd_data), 32'd1);

    // Lock-up recovery: Q forced to 000 in SERVE.
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);
    force dut.u_lfsr.q_reg = 3'b000;
    m_q_zero = 1'b1;
    tick(4'b0001, 1'b0);
    check("lockup_nogrant", 32'(gnt), 32'd0);
    check("lockup_busy", 32'(busy), 32'd1);
    release dut.u_lfsr.q_reg;
    tick(4'b0001, 1'b0);
    tick(4'b0001, 1'b0);
    check("lockup_gnt", 32'(gnt), 32'b0001);
    check("lockup_data", 32'(rnd_data), 32'd1);

    // Reset while a grant is showing; afterwards ptr restarts at 0.
    tick(4'b0000, 1'b0);
    tick(4'b0010, 1'b0);
    check("pre_reset_gnt", 32'(gnt), 32'b0010);
    do_reset();
    check("midgrant_valid", 32'(rnd_valid), 32'd0);
    tick(4'b0010, 1'b0);
    tick(4'b0011, 1'b0);
    check("post_reset_gnt", 32'(gnt), 32'b0001);
    check("post_reset_data", 32'(rnd_data), 32'd1);
    tick(4'b0011, 1'b0);
    check("post_reset_gnt2", 32'(gnt), 32'b0010);

    // Randomized traffic with occasional reseed pulses.
    for (int i = 0; i < 400; i++) begin
      tick(4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_arbiter.md
# lfsr_arbiter

Shares one 3-bit pseudo-random generator between `N_REQ` requesters with a round-robin req/gnt handshake. Each grant delivers one LFSR word and advances the generator by one step. The block seeds the generator after reset and on request, and recovers it from the all-zero lock-up state. It sits between the random-number consumers (test-pattern, dither, backoff logic) and the LFSR register.

## Interface
- `N_REQ`, 4: number of requesters; fixed at 4 in this revision (`rnd_id` is 2 bits).
- `SEED`, 3'b001: value loaded into the LFSR on (re)seed; must be non-zero.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input `N_REQ`: request per requester; level, held until granted.
- `reseed` input 1: single-cycle pulse; reload `SEED` at the next opportunity.
- `gnt` output `N_REQ`: registered, one-hot or zero; single-cycle grant pulse.
- `rnd_valid` output 1: registered; high in exactly the cycles where `gnt` is non-zero.
- `rnd_data` output 3: registered LFSR word for the granted requester; holds its last value when `rnd_valid` is 0.
- `rnd_id` output 2: registered index of the granted requester.
- `busy` output 1: high while in LOAD; no grants are issued in that state.

## Operation
- States: LOAD, SERVE. Reset enters LOAD.
- **LOAD** (1 cycle):
  - LFSR load is asserted, so `Q <= SEED`.
  - No grant is issued.
  - Next state is SERVE.
- **SERVE**:
  - Eligible set = `req & ~gnt`. A requester whose grant is currently high is ignored for one cycle, which prevents a double grant from its still-high `req`.
  - If the eligible set is non-zero: select the first set bit searching upward from `ptr`, wrapping from bit 3 to bit 0.
  - On that selection, register:
    - `gnt` = one-hot of the selected bit
    - `rnd_id` = the selected index
    - `rnd_data` = current `Q`
    - `rnd_valid` = 1
  - Also on that selection: advance `Q`, and set `ptr` = (selected index + 1) mod 4.
  - If the eligible set is zero: `gnt` = 0, `rnd_valid` = 0, and `Q` and `ptr` hold.
- LFSR step: `Q_next = {Q[1], Q[2]^Q[0], Q[2]}`. Period is 7, with the sequence from 001 being 001, 010, 100, 011, 110, 111, 101, then 001 again.
- `reseed` sampled high in SERVE: go to LOAD. No grant is issued on that edge, even if requests are pending; they are served after LOAD completes.
- `reseed` sampled high in LOAD: ignored, because the seed is already being loaded.
- Lock-up: if `Q == 0` in SERVE, go to LOAD instead of granting.

## Timing
- Reset values:
  - `gnt` = 0, `rnd_valid` = 0, `rnd_data` = 000, `rnd_id` = 0
  - `busy` = 1, state = LOAD, `ptr` = 0, `Q` = 000
- First edge after `reset_n` rises: `Q` = `SEED`, `busy` = 0.
- Grant latency: `req` sampled at edge t gives `gnt`/`rnd_data` valid during cycle t+1, at the earliest.
- Throughput: 1 grant per cycle overall. A single requester holding `req` is granted every other cycle.
- Reseed latency: `reseed` at edge t puts LOAD in cycle t+1 (`busy`=1). The seeded word is available for a grant sampled at edge t+2, with `gnt` high in cycle t+3.
- `reset_n` asserted mid-grant: all outputs clear immediately (asynchronously). The grant is lost, and the requester must keep `req` high to be served again.

## Structure
- Shared package holds:
  - `LFSR_W` = 3
  - the state encoding (`ST_LOAD`, `ST_SERVE`)
  - `DEFAULT_SEED` = 3'b001
- Sub-module `lfsr_step` holds the 3-bit register, load mux and tap logic.
  - Ports: `clk`, `reset_n`, `load`, `step`, `seed`, `q`.
  - Step enable: `Q` advances only when `step` is high.
- The arbiter holds the FSM, `ptr`, the round-robin priority select and the output registers.

## Test plan
- Reset release, `req`=0000: `busy` = 1 then 0 on the first edge; `gnt` stays 0; internal `Q` = 001.
- `req`=0100 held: `gnt` = 0100 in alternate cycles, with `rnd_data` = 001, 010, 100, 011, …. The 8th grant returns 001 (period-7 wrap).
- `req`=1111 held from seeded state: `rnd_id` order 0, 1, 2, 3, 0, … with `rnd_data` 001, 010, 100, 011, 110.
- After 3 grants, pulse `reseed` with `req`=0011 pending: next cycle no grant and `busy`=1; the next grant carries `rnd_data`=001 to the requester at `ptr`.
- Force `Q`=000 in SERVE (backdoor) with `req`=0001: no grant; LOAD cycle; then `gnt`=0001 with `rnd_data`=001.
- Drop `reset_n` while `gnt`=0010: all outputs 0 immediately; after release, LOAD, then the grant resumes with `ptr`=0.
